// File: rtl/mem_responder.sv
// mem_responder: wait-stated unified memory answering MemRead/MemWrite with a one-cycle mem_ready pulse.
// Define MEM_MISALIGN_TRAP_EN to suppress accesses with addr[1:0]!=0 and flag them on err.
module mem_responder #(
  parameter int DEPTH = 256,
  parameter int ADDR_W = 8,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        mem_ready,
  output logic        busy,
  output logic        err
);
  typedef enum logic [1:0] {IDLE, WAIT, RESP, DRAIN} state_t;
  state_t state, nxt;
  logic [31:0] mem [DEPTH];
  logic [3:0] cnt;
  logic wr;
  logic [ADDR_W-1:0] idx;
  logic [31:0] wd;
  logic req, fire, ok;
  logic unused_bits;
  assign req = MemRead | MemWrite;
  assign fire = state == WAIT && cnt == 4'd0;
  assign mem_ready = state == RESP;
  assign busy = state != IDLE;
  assign unused_bits = ^{addr[31:ADDR_W+2], addr[1:0]};
`ifdef MEM_MISALIGN_TRAP_EN
  logic mis;
  assign ok = !mis;
  assign err = state == RESP && mis;
`else
  assign ok = 1'b1;
  assign err = 1'b0;
`endif
  always_comb begin
    nxt = state;
    nxt = state == IDLE ? (req ? WAIT : IDLE) :
          state == WAIT ? (cnt == 4'd0 ? RESP : WAIT) :
          (req ? DRAIN : IDLE);
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      cnt <= '0;
      wr <= 1'b0;
      idx <= '0;
      wd <= '0;
      rdata <= '0;
`ifdef MEM_MISALIGN_TRAP_EN
      mis <= 1'b0;
`endif
    end else begin
      state <= nxt;
      if (state == IDLE && req) begin
        wr <= MemWrite;
        idx <= addr[ADDR_W+1:2];
        wd <= wdata;
        cnt <= 4'(WAIT_CYCLES);
`ifdef MEM_MISALIGN_TRAP_EN
        mis <= |addr[1:0];
`endif
      end else if (state == WAIT && cnt != 4'd0) cnt <= cnt - 4'd1;
      if (fire && !wr && ok) rdata <= mem[idx];
    end
  // state is forced to IDLE by reset, so an aborted write can never reach this point
  always_ff @(posedge clk)
    if (fire && wr && ok) mem[idx] <= wd;
endmodule
